// File: rtl/fetch_controller_if.sv
// Fetch controller bundle: instruction memory port, decode handshake, control and status.
interface fetch_controller_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_pc;
  logic [31:0]   imem_inst;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [CW-1:0] queue_count;
  logic [31:0]   fetched_total;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_inst, out_ready,
    output imem_pc, out_valid, out_pc, out_inst, queue_count, fetched_total
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_inst, out_ready,
    input  imem_pc, out_valid, out_pc, out_inst, queue_count, fetched_total
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads a zero-latency memory and
// buffers {pc, inst} pairs in an in-order queue for decode; redirect flushes.
module fetch_controller #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  fetch_controller_if.master  bus
);
  localparam int unsigned PW        = $clog2(DEPTH);
  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic {RUN, HOLD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   total_q, total_d;
  logic          deq_c, enq_c;
  logic [31:0]   pc_inc_c, target_c;

  // Next-state: handshake decode, queue bookkeeping, PC sequencing and RUN/HOLD.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    total_d  = total_q;
    deq_c    = 1'b0;
    enq_c    = 1'b0;
    pc_inc_c = pc_q + 32'd4;
    target_c = (bus.redirect_pc & 32'hFFFF_FFFC) % MEM_LIMIT;

    deq_c = (count_q != '0) & bus.out_ready;
    if (state_q == HOLD) begin
      enq_c = bus.fetch_en & ~bus.redirect_valid & deq_c;
    end else begin
      enq_c = bus.fetch_en & ~bus.redirect_valid &
              ((count_q < CW'(DEPTH)) | deq_c);
    end

    if (bus.redirect_valid) begin
      state_d = RUN;
      pc_d    = target_c;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq_c) head_d = head_q + PW'(1);
      if (enq_c) begin
        tail_d  = tail_q + PW'(1);
        total_d = total_q + 32'd1;
        pc_d    = (pc_inc_c >= MEM_LIMIT) ? 32'd0 : pc_inc_c;
      end
      count_d = count_q + CW'(enq_c) - CW'(deq_c);

      case (state_q)
        RUN:     if ((count_q == CW'(DEPTH)) && !deq_c) state_d = HOLD;
        HOLD:    if (deq_c) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      total_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      total_q <= total_d;
      if (enq_c) mem_q[tail_q] <= '{pc: pc_q, inst: bus.imem_inst};
    end
  end

  // Head presentation is a plain mux of registered storage.
  assign bus.imem_pc       = pc_q;
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_pc        = mem_q[head_q].pc;
  assign bus.out_inst      = mem_q[head_q].inst;
  assign bus.queue_count   = count_q;
  assign bus.fetched_total = total_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: queue-based reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_fetch_controller;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MEM_BYTES = 1024;
  localparam logic [31:0] KEY       = 32'hA5A5_0000;

  logic clk;
  logic reset;
  fetch_controller_if #(.DEPTH(DEPTH)) bus ();

  fetch_controller #(.DEPTH(DEPTH), .RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign bus.imem_inst = bus.imem_pc ^ KEY;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: abstract queue of fetched {pc,inst}.
  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic [31:0] mtotal;
  bit          check_en = 0;

  always @(posedge clk) begin
    logic do_deq, do_enq;
    logic [31:0] nxt;
    if (reset) begin
      mq.delete();
      mpc    = 32'h0;
      mtotal = 32'h0;
    end else if (bus.redirect_valid) begin
      mq.delete();
      mpc = (bus.redirect_pc & 32'hFFFF_FFFC) % MEM_BYTES;
    end else begin
      do_deq = (mq.size() != 0) && bus.out_ready;
      do_enq = bus.fetch_en && ((mq.size() < DEPTH) || do_deq);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        mq.push_back({mpc, mpc ^ KEY});
        nxt    = mpc + 4;
        mpc    = (nxt >= MEM_BYTES) ? 32'h0 : nxt;
        mtotal = mtotal + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("imem_pc", bus.imem_pc, mpc);
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      check("queue_count", 32'(bus.queue_count), 32'(mq.size()));
      check("fetched_total", bus.fetched_total, mtotal);
      if (mq.size() != 0) begin
        check("out_pc", bus.out_pc, mq[0][63:32]);
        check("out_inst", bus.out_inst, mq[0][31:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    logic [31:0] drain_exp [4];
    logic [3:0]  en_seq;
    logic [31:0] en_pc [4];

    reset              = 1'b1;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    step(2);
    check_en = 1;

    // Reset state.
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_count", 32'(bus.queue_count), 32'h0);
    check("rst_imem_pc", bus.imem_pc, 32'h0);

    // Streaming at one per cycle.
    reset = 1'b0; bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("stream_pc", bus.out_pc, 32'(i * 4));
    end
    check("stream_total", bus.fetched_total, 32'd4);

    // Backpressure from a fresh reset, then drain.
    do_reset();
    bus.out_ready = 1'b0;
    step(6);
    check("bp_count", 32'(bus.queue_count), 32'd4);
    check("bp_imem_pc", bus.imem_pc, 32'd16);
    check("bp_out_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    drain_exp = '{32'd4, 32'd8, 32'd12, 32'd16};
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("drain_pc", bus.out_pc, drain_exp[i]);
    end

    // Redirect with three entries queued.
    do_reset();
    bus.out_ready = 1'b0;
    step(3);
    check("pre_redir_count", 32'(bus.queue_count), 32'd3);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0086; bus.out_ready = 1'b1;
    step(1);
    bus.redirect_valid = 1'b0;
    check("redir_count", 32'(bus.queue_count), 32'h0);
    check("redir_valid", 32'(bus.out_valid), 32'h0);
    check("redir_imem_pc", bus.imem_pc, 32'h84);
    step(1);
    check("redir_out_pc", bus.out_pc, 32'h84);
    check("redir_out_valid", 32'(bus.out_valid), 32'h1);

    // Wrap at the memory boundary.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_03F8;
    step(1);
    bus.redirect_valid = 1'b0;
    wrap_exp = '{32'h3F8, 32'h3FC, 32'h000, 32'h004};
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("wrap_pc", bus.out_pc, wrap_exp[i]);
    end

    // fetch_en gating: 1,0,0,1.
    en_seq = 4'b1001;
    en_pc  = '{32'd12, 32'd12, 32'd12, 32'd16};
    for (int i = 0; i < 4; i++) begin
      bus.fetch_en = en_seq[3-i];
      step(1);
      check("en_imem_pc", bus.imem_pc, en_pc[i]);
    end
    bus.fetch_en = 1'b1;

    // Reset while full and redirecting.
    bus.out_ready = 1'b0;
    step(5);
    check("full_count", 32'(bus.queue_count), 32'd4);
    reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    step(1);
    reset = 1'b0; bus.redirect_valid = 1'b0;
    check("rst2_valid", 32'(bus.out_valid), 32'h0);
    check("rst2_count", 32'(bus.queue_count), 32'h0);
    check("rst2_imem_pc", bus.imem_pc, 32'h0);
    check("rst2_total", bus.fetched_total, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.fetch_en       = ($urandom_range(3) != 0);
      bus.out_ready      = (i % 400 < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      bus.redirect_valid = ($urandom_range(15) == 0);
      bus.redirect_pc    = $urandom;
      reset              = ($urandom_range(299) == 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
